register_univ_r: RTL
====================

# register_univ_r

Parametrised universal register for the traffic-light controller datapath. It is a WIDTH-bit state and timer register. Every clock it holds, loads, counts up or down with a wrap or saturate policy, shifts, rotates or synchronously clears. It also provides zero-detect, a registered overflow pulse and a registered serial-out bit. It is the successor to the fixed-width plain load registers and serves as state register, phase timer or shift-based light pattern generator.

## Interface
Parameters:
- WIDTH, 3: register width in bits; legal range ≥ 2.
- RESET_VALUE, 0: value of q after asynchronous reset and after the CLR op; WIDTH bits.
- SATURATE, 0: counting policy.
  - 0: INC and DEC wrap around.
  - 1: INC sticks at all-ones and DEC sticks at zero.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  op enable; when 0 the register holds.
- op  input  3  operation select, sampled on the rising clk edge when en=1.
- d  input  WIDTH  parallel load data.
- si  input  1  serial input for SHL/SHR.
- q  output  WIDTH  registered register contents.
- zero  output  1  combinational (q == 0).
- ovf  output  1  registered one-cycle overflow/underflow pulse.
- sout  output  1  registered bit shifted out by the last SHL/SHR.

## Operation
- Reset (reset_n=0): immediately, without a clock, q=RESET_VALUE, ovf=0, sout=0. All of these hold while reset_n=0.
- op encoding, applied on a rising clk edge when en=1:
  - 000 HOLD: q unchanged.
  - 001 LOAD: q←d.
  - 010 INC: q←q+1.
    - When q is all-ones, q←0 if SATURATE=0; q unchanged if SATURATE=1.
  - 011 DEC: q←q−1.
    - When q=0, q←all-ones if SATURATE=0; q unchanged if SATURATE=1.
  - 100 SHL: q←{q[WIDTH-2:0], si}; sout←q[WIDTH-1].
  - 101 SHR: q←{si, q[WIDTH-1:1]}; sout←q[0].
  - 110 ROL: q←{q[WIDTH-2:0], q[WIDTH-1]}; sout unchanged.
  - 111 CLR: q←RESET_VALUE; this is synchronous, and ovf and sout are unaffected by it.
- ovf:
  - Set to 1 for exactly the cycle after INC executes at all-ones, or DEC executes at zero. This applies under both SATURATE settings.
  - Cleared to 0 after every other clocked edge, including edges with en=0.
- sout: updates only on SHL/SHR with en=1 and otherwise holds its last value.
- en=0: q and sout hold; ovf←0; op, d and si are ignored.
- Arithmetic is modulo 2^WIDTH with no sign interpretation. No carry is propagated beyond ovf.
- Any op value is legal; there is no illegal state.

## Timing
- Latency: q, ovf and sout reflect the op one clock after the sampling edge. zero follows q combinationally in the same cycle.
- Back-to-back ops are allowed every cycle; there is no handshake and no busy state.
- Reset asserted mid-sequence overrides any op in progress in the same cycle.
- At the first rising edge after reset_n deasserts, the register samples normally. Deassertion must meet recovery timing relative to clk, which is the integrator's responsibility.
- Simultaneous events: en=1 with op=CLR while ovf=1 from the previous cycle → q=RESET_VALUE and ovf=0 on the next edge.
- q must never show X after reset, whatever op/d/si were during reset.

## Test plan
Directed scenarios, all at WIDTH=3:
- Reset and hold, RESET_VALUE=5:
  - Assert reset_n=0 mid-clock → q=5, ovf=0, sout=0 immediately with no clock edge.
  - Release reset, then op=HOLD for 3 cycles → q stays 5 and zero=0.
- Wrap counting, SATURATE=0:
  - LOAD 6, then INC ×2 → q=7, then q=0 with ovf=1 for one cycle and zero=1.
  - Then DEC → q=7 and ovf=1.
- Saturate counting, SATURATE=1:
  - LOAD 7, then INC → q=7 and ovf=1.
  - Next INC → q=7 and ovf=1 again; then HOLD → ovf=0.
  - LOAD 0, then DEC → q=0 and ovf=1.
- Shift and rotate:
  - LOAD 3'b101, SHL with si=0 → q=3'b010, sout=1.
  - SHR with si=1 → q=3'b101, sout=0.
  - ROL → q=3'b011, sout stays 0.
- Enable gating:
  - Issue INC at q=7 to get ovf=1, then drive en=0 with op=LOAD and d=2 for 2 cycles → q unchanged and ovf drops to 0 on the first edge.
  - Then en=1 with CLR → q=RESET_VALUE.
- Async reset mid-run:
  - Run INC continuously from q=0 and pulse reset_n low for half a cycle at q=3 → q=RESET_VALUE immediately.
  - After release, counting resumes from RESET_VALUE on the next edge.

Source files
------------

// File: rtl/register_univ_r.sv
// ---------------------------------------------------------------------------
// register_univ_r
// Universal WIDTH-bit state/timer register for the traffic-light datapath.
// Each clock it can hold, load, count up/down (wrap or saturate), shift,
// rotate or synchronously clear. It also provides a zero flag, a one-cycle
// overflow pulse and the bit most recently shifted out.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (q=RESET_VALUE, ovf=0, sout=0)
//   en       operation enable; 0 = hold q/sout and clear ovf
//   op       operation select (HOLD/LOAD/INC/DEC/SHL/SHR/ROL/CLR)
//   d        parallel load data
//   si       serial input for SHL/SHR
//   q        registered register contents
//   zero     combinational (q == 0)
//   ovf      registered overflow/underflow pulse
//   sout     registered bit shifted out by the last SHL/SHR
// ---------------------------------------------------------------------------
module register_univ_r #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter bit               SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             ovf,
    output logic             sout
);

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_r;
    logic             ovf_r;
    logic             sout_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic             ovf_nxt_s;
    logic             sout_nxt_s;

    // Next-state decode: ovf defaults to 0 so it only pulses for one cycle.
    always_comb begin
        q_nxt_s    = q_r;
        ovf_nxt_s  = 1'b0;
        sout_nxt_s = sout_r;
        if (en == 1'b1) begin
            case (op)
                OP_HOLD: begin
                    q_nxt_s = q_r;
                end
                OP_LOAD: begin
                    q_nxt_s = d;
                end
                OP_INC: begin
                    if (q_r == ALL_ONES) begin
                        ovf_nxt_s = 1'b1;
                        if (SATURATE == 1'b1) begin
                            q_nxt_s = q_r;
                        end else begin
                            q_nxt_s = ALL_ZERO;
                        end
                    end else begin
                        q_nxt_s = q_r + ONE;
                    end
                end
                OP_DEC: begin
                    if (q_r == ALL_ZERO) begin
                        ovf_nxt_s = 1'b1;
                        if (SATURATE == 1'b1) begin
                            q_nxt_s = q_r;
                        end else begin
                            q_nxt_s = ALL_ONES;
                        end
                    end else begin
                        q_nxt_s = q_r - ONE;
                    end
                end
                OP_SHL: begin
                    q_nxt_s    = {q_r[WIDTH-2:0], si};
                    sout_nxt_s = q_r[WIDTH-1];
                end
                OP_SHR: begin
                    q_nxt_s    = {si, q_r[WIDTH-1:1]};
                    sout_nxt_s = q_r[0];
                end
                OP_ROL: begin
                    // Rotation loses no bit, so sout keeps its last value.
                    q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                end
                OP_CLR: begin
                    q_nxt_s = RESET_VALUE;
                end
                default: begin
                    q_nxt_s = q_r;
                end
            endcase
        end else begin
            q_nxt_s = q_r;
        end
    end

    // State registers with asynchronous reset to the configured value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r    <= RESET_VALUE;
            ovf_r  <= 1'b0;
            sout_r <= 1'b0;
        end else begin
            q_r    <= q_nxt_s;
            ovf_r  <= ovf_nxt_s;
            sout_r <= sout_nxt_s;
        end
    end

    assign q    = q_r;
    assign ovf  = ovf_r;
    assign sout = sout_r;
    assign zero = (q_r == ALL_ZERO);

endmodule
